// File: rtl/stream_packet_summer.sv
// AXI-Stream packet summer: accumulates byte-masked beats and emits a two-beat
// summary (sum, then beat count). Define STREAM_SUMMER_SATURATE_EN to clamp the sum on overflow.
module stream_packet_summer #(
  parameter int TDATA_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       axis_aclk,
  input  logic                       axis_areset,
  output logic                       s00_axis_tready,
  input  logic [TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                       s00_axis_tlast,
  input  logic                       s00_axis_tvalid,
  output logic                       m00_axis_tvalid,
  output logic [TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                       m00_axis_tlast,
  input  logic                       m00_axis_tready,
  output logic                       overflow,
  output logic [1:0]                 state
);

  localparam int NBYTES = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ACCUM    = 2'b00,
    SEND_SUM = 2'b01,
    SEND_CNT = 2'b10,
    UNUSED   = 2'b11
  } state_t;

  state_t                  state_reg;
  logic [TDATA_WIDTH-1:0]  acc_reg;
  logic [CNT_WIDTH-1:0]    cnt_reg;
  logic                    overflow_reg;
  logic                    s_tready_reg;
  logic                    m_tvalid_reg;
  logic                    m_tlast_reg;
  logic [TDATA_WIDTH-1:0]  m_tdata_reg;

  logic [TDATA_WIDTH-1:0]  masked_data;
  logic [TDATA_WIDTH:0]    acc_sum;
  logic [TDATA_WIDTH-1:0]  acc_next;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic [TDATA_WIDTH-1:0]  cnt_ext;
  logic                    ovf_next;
  logic                    beat_accept;

  // A cleared strobe bit zeroes its byte before it reaches the adder.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_mask
      assign masked_data[gi*8 +: 8] = s00_axis_tdata[gi*8 +: 8] & {8{s00_axis_tstrb[gi]}};
    end
  endgenerate

  always_comb begin
    beat_accept = s00_axis_tvalid && s_tready_reg;
    acc_sum     = {1'b0, acc_reg} + {1'b0, masked_data};
    ovf_next    = overflow_reg | acc_sum[TDATA_WIDTH];
`ifdef STREAM_SUMMER_SATURATE_EN
    acc_next    = ovf_next ? {TDATA_WIDTH{1'b1}} : acc_sum[TDATA_WIDTH-1:0];
`else
    acc_next    = acc_sum[TDATA_WIDTH-1:0];
`endif
    cnt_next    = (cnt_reg == {CNT_WIDTH{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    cnt_ext     = '0;
    cnt_ext[CNT_WIDTH-1:0] = cnt_reg;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_reg    <= ACCUM;
      s_tready_reg <= 1'b0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      m_tdata_reg  <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          s_tready_reg <= 1'b1;
          if (beat_accept) begin
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            overflow_reg <= ovf_next;
            // The sum beat already includes the tlast beat itself.
            if (s00_axis_tlast) begin
              m_tdata_reg  <= acc_next;
              m_tvalid_reg <= 1'b1;
              s_tready_reg <= 1'b0;
              state_reg    <= SEND_SUM;
            end
          end
        end
        SEND_SUM: begin
          s_tready_reg <= 1'b0;
          if (m00_axis_tready) begin
            m_tdata_reg <= cnt_ext;
            m_tlast_reg <= 1'b1;
            state_reg   <= SEND_CNT;
          end
        end
        SEND_CNT: begin
          s_tready_reg <= 1'b0;
          if (m00_axis_tready) begin
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
            s_tready_reg <= 1'b1;
            state_reg    <= ACCUM;
          end
        end
        default: begin
          state_reg    <= ACCUM;
          s_tready_reg <= 1'b0;
          m_tvalid_reg <= 1'b0;
          m_tlast_reg  <= 1'b0;
          m_tdata_reg  <= '0;
          acc_reg      <= '0;
          cnt_reg      <= '0;
          overflow_reg <= 1'b0;
        end
      endcase
    end
  end

  assign s00_axis_tready = s_tready_reg;
  assign m00_axis_tvalid = m_tvalid_reg;
  assign m00_axis_tdata  = m_tdata_reg;
  assign m00_axis_tstrb  = {NBYTES{1'b1}};
  assign m00_axis_tlast  = m_tlast_reg;
  assign overflow        = overflow_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_stream_packet_summer.sv
// Bench for stream_packet_summer: directed packets plus random traffic checked
// against a packet-level model; honours STREAM_SUMMER_SATURATE_EN.
module tb_stream_packet_summer;
  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          s_tready;
  logic [W-1:0]  s_tdata = '0;
  logic [3:0]    s_tstrb = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          m_tvalid;
  logic [W-1:0]  m_tdata;
  logic [3:0]    m_tstrb;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          overflow;
  logic [1:0]    state;

  typedef struct { logic [31:0] data; logic last; logic ovf; } exp_t;
  typedef struct { logic [31:0] sum; logic [31:0] cnt; logic ovf; } summ_t;

  exp_t              exp_q[$];
  longint unsigned   cur_d[$];
  logic [31:0]       obs_d[$];
  logic              obs_o[$];
  int                pass_cnt = 0;
  int                total_cnt = 0;
  bit                hold_low = 1'b0;
  bit                rand_rdy = 1'b0;

  stream_packet_summer #(.TDATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .axis_aclk       (clk),
    .axis_areset     (srst),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tvalid (s_tvalid),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .overflow        (overflow),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // Packet-level model: plain sum of masked beats, compared against the word range.
  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic summ_t summarize(input longint unsigned v[$]);
    summ_t r;
    longint unsigned tot = 0;
    foreach (v[i]) tot += v[i];
    r.ovf = (tot > 64'hFFFF_FFFF);
`ifdef STREAM_SUMMER_SATURATE_EN
    r.sum = r.ovf ? 32'hFFFF_FFFF : tot[31:0];
`else
    r.sum = tot[31:0];
`endif
    r.cnt = (v.size() > CMAX) ? CMAX : v.size();
    return r;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit ok = 1'b0;
    summ_t sm;
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = s; s_tlast = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL accept_timeout got=0 expected=1 at %0t", $time);
    end else begin
      cur_d.push_back(longint'(mask_word(d, s)));
      if (last) begin
        sm = summarize(cur_d);
        exp_q.push_back('{sm.sum, 1'b0, sm.ovf});
        exp_q.push_back('{sm.cnt, 1'b1, sm.ovf});
        cur_d.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain;
    bit done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_tvalid) begin done = 1'b1; break; end
    end
    check("drain", done, 1);
  endtask

  task automatic do_reset;
    s_tvalid = 1'b0; s_tlast = 1'b0; srst = 1'b1;
    cur_d.delete(); exp_q.delete();
    @(posedge clk); #1; srst = 1'b0;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready_after", s_tready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_obs2(input string name, input logic [31:0] e0, input logic [31:0] e1);
    check({name, "_n"}, obs_d.size(), 2);
    if (obs_d.size() >= 2) begin
      check({name, "_sum"}, obs_d[0], e0);
      check({name, "_cnt"}, obs_d[1], e1);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = hold_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Single compare process: every output handshake against the model, plus hold rules.
  initial begin
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (srst) begin prev_stall = 1'b0; continue; end
      if (m_tvalid && s_tready) check("ready_exclusive", 1, 0);
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        obs_d.push_back(m_tdata);
        obs_o.push_back(overflow);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_last", m_tlast, e.last);
          check("out_ovf", overflow, e.ovf);
          check("out_strb", m_tstrb, 4'hF);
          check("out_state", state, e.last ? 2 : 1);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  initial begin
    longint unsigned pin_q[$];
    summ_t pin;
    logic [31:0] d;
    logic [3:0] s;

    // Hand-computed anchors for the model itself.
    pin_q = '{64'd1, 64'd2, 64'd3};
    pin = summarize(pin_q);
    check("pin_sum3", pin.sum, 32'h6);
    check("pin_cnt3", pin.cnt, 3);
    check("pin_mask", mask_word(32'hFFFF_FFFF, 4'b0011), 32'h0000_FFFF);
    pin_q = '{64'hFFFF_FFF0, 64'h20};
    pin = summarize(pin_q);
    check("pin_ovf", pin.ovf, 1);
`ifdef STREAM_SUMMER_SATURATE_EN
    check("pin_ovf_sum", pin.sum, 32'hFFFF_FFFF);
`else
    check("pin_ovf_sum", pin.sum, 32'h10);
`endif

    @(posedge clk); #1;
    do_reset();

    // Three-beat packet.
    obs_d.delete(); obs_o.delete();
    send_beat(32'h1, 4'hF, 1'b0);
    send_beat(32'h2, 4'hF, 1'b0);
    send_beat(32'h3, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    check_obs2("p3", 32'h6, 32'h3);

    // Single beat, partial strobe.
    obs_d.delete(); obs_o.delete();
    send_beat(32'hFFFF_FFFF, 4'b0011, 1'b1);
    idle(1);
    wait_drain();
    check_obs2("strb", 32'h0000_FFFF, 32'h1);

    // Sum overflow.
    obs_d.delete(); obs_o.delete();
    send_beat(32'hFFFF_FFF0, 4'hF, 1'b0);
    send_beat(32'h20, 4'hF, 1'b1);
    idle(1);
    wait_drain();
`ifdef STREAM_SUMMER_SATURATE_EN
    check_obs2("ovf", 32'hFFFF_FFFF, 32'h2);
`else
    check_obs2("ovf", 32'h10, 32'h2);
`endif
    if (obs_o.size() >= 1) check("ovf_flag", obs_o[0], 1);

    // Downstream stall for 5 cycles on the sum beat.
    obs_d.delete(); obs_o.delete();
    hold_low = 1'b1;
    idle(2);
    send_beat(32'h5, 4'hF, 1'b0);
    send_beat(32'h7, 4'hF, 1'b1);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", m_tvalid, 1);
      check("stall_data", m_tdata, 32'hC);
      check("stall_s_ready", s_tready, 0);
      @(posedge clk); #1;
    end
    hold_low = 1'b0;
    wait_drain();
    check_obs2("stall", 32'hC, 32'h2);

    // Reset in the middle of a packet discards the partial sum.
    send_beat(32'h11, 4'hF, 1'b0);
    send_beat(32'h22, 4'hF, 1'b0);
    do_reset();
    obs_d.delete(); obs_o.delete();
    send_beat(32'h9, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    check_obs2("after_rst", 32'h9, 32'h1);

    // Back-to-back packets with tvalid held high.
    obs_d.delete(); obs_o.delete();
    send_beat(32'h1, 4'hF, 1'b1);
    send_beat(32'h2, 4'hF, 1'b0);
    send_beat(32'h3, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    check("b2b_n", obs_d.size(), 4);
    if (obs_d.size() >= 4) begin
      check("b2b_0", obs_d[0], 32'h1);
      check("b2b_1", obs_d[1], 32'h1);
      check("b2b_2", obs_d[2], 32'h5);
      check("b2b_3", obs_d[3], 32'h2);
    end

    // Beat counter saturation (CW-bit counter).
    obs_d.delete(); obs_o.delete();
    for (int b = 0; b < 20; b++) send_beat(32'h1, 4'hF, b == 19);
    idle(1);
    wait_drain();
    check_obs2("cnt_sat", 32'd20, CMAX);

    // Random traffic with gaps and random downstream ready.
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        d = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 255));
        s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        send_beat(d, s, b == len - 1);
      end
    end
    idle(1);
    wait_drain();
    rand_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/stream_packet_summer.md
Name: stream_packet_summer

Overview:
- AXI-Stream stage placed directly downstream of the right-shift stage; consumes its shifted words.
- Accumulates every beat of a packet and counts the beats.
- On tlast, emits a 2-beat summary packet: beat 0 is the sum, beat 1 is the beat count, with tlast on beat 1.
- Used to check and characterise streamed data without CPU involvement.

Parameters:
- TDATA_WIDTH, 32: data width of both stream interfaces. Must be a multiple of 8.
- CNT_WIDTH, 16: width of the internal beat counter. Must be ≤ TDATA_WIDTH.

Ports:
- axis_aclk  input  1  single clock for both interfaces.
- axis_areset  input  1  synchronous reset, active-high.
- s00_axis_tready  output  1  upstream ready.
- s00_axis_tdata  input  TDATA_WIDTH  upstream data.
- s00_axis_tstrb  input  TDATA_WIDTH/8  byte qualifiers. A 0 bit means that byte is treated as zero.
- s00_axis_tlast  input  1  marks the last beat of the packet.
- s00_axis_tvalid  input  1  upstream valid.
- m00_axis_tvalid  output  1  downstream valid.
- m00_axis_tdata  output  TDATA_WIDTH  summary word (sum, then count).
- m00_axis_tstrb  output  TDATA_WIDTH/8  tied to all ones.
- m00_axis_tlast  output  1  high on the count beat only.
- m00_axis_tready  input  1  downstream ready.
- overflow  output  1  sticky for the current packet: the sum exceeded 2^TDATA_WIDTH-1.
- state  output  2  debug copy of the FSM state.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - All registers update on the posedge of axis_aclk only.
- Reset values:
  - state = ACCUM (2'b00)
  - s00_axis_tready = 0 (ACCUM sets it to 1 on the first clock after reset)
  - m00_axis_tvalid = 0, m00_axis_tlast = 0, m00_axis_tdata = 0
  - accumulator = 0, counter = 0, overflow = 0
- FSM states:
  - ACCUM = 00
  - SEND_SUM = 01
  - SEND_CNT = 10
  - 11 is unused and returns to ACCUM with all outputs cleared.
- ACCUM:
  - s00_axis_tready = 1.
  - A beat is accepted when tvalid && tready.
  - Masked data is tdata with each byte ANDed by its replicated tstrb bit.
  - The accumulator is TDATA_WIDTH+1 bits: acc_next = acc + masked.
  - If the carry bit is set, overflow is set (sticky).
  - The counter increments and saturates at 2^CNT_WIDTH-1.
  - If the accepted beat has tlast:
    - The final sum and final count include that beat.
    - m00_axis_tdata <= final sum.
    - m00_axis_tvalid <= 1.
    - s00_axis_tready <= 0.
    - Next state is SEND_SUM.
  - Latency: the sum beat is valid on the cycle after the tlast beat is accepted.
- SEND_SUM:
  - s00_axis_tready = 0.
  - tdata and tvalid hold stable while tready is low.
  - On m00_axis_tready:
    - tdata <= counter zero-extended to TDATA_WIDTH.
    - tlast <= 1.
    - Next state is SEND_CNT.
- SEND_CNT:
  - On m00_axis_tready:
    - tvalid <= 0, tlast <= 0.
    - accumulator, counter and overflow <= 0.
    - s00_axis_tready <= 1.
    - Next state is ACCUM.
  - No bubble beyond that one cycle: a new packet can be accepted on the following cycle.
- Boundary conditions:
  - A single-beat packet (tlast on the first beat) gives count = 1.
  - s00_axis_tvalid low in ACCUM: hold the current state, no change.
  - Upstream data presented while in a SEND state is not accepted (tready = 0) and must be held by upstream.
  - Reset mid-packet or mid-send: the partial packet is discarded and outputs go to their reset values on the next edge. tvalid dropping without a handshake is permitted only under reset.
  - Sum overflow without the optional feature: the sum wraps modulo 2^TDATA_WIDTH. overflow still flags it.

Optional Feature:
- Macro: STREAM_SUMMER_SATURATE_EN.
- Defined:
  - Once overflow is set, the accumulator is clamped to all ones for the rest of the packet.
  - The sum beat reports 2^TDATA_WIDTH-1.
- Undefined:
  - The accumulator wraps modulo 2^TDATA_WIDTH.
  - The overflow flag behaves identically in both builds.

Test Plan:
- Packet of 3 beats 0x1, 0x2, 0x3 (tlast on 0x3), tstrb=0xF, m tready=1 -> output beats 0x00000006, then 0x00000003 with tlast=1. overflow=0.
- Single beat 0xFFFFFFFF with tstrb=4'b0011 and tlast -> sum 0x0000FFFF, count 0x00000001.
- Beats 0xFFFFFFF0 and 0x00000020 (tlast) -> overflow=1. Sum is 0xFFFFFFFF with STREAM_SUMMER_SATURATE_EN, 0x00000010 without. Count 2.
- Packet 0x5, 0x7 (tlast) with m00_axis_tready low for 5 cycles after tvalid rises -> tvalid stays 1, tdata holds 0x0000000C, s00_axis_tready stays 0. When ready rises: 0x0C, then 0x02 with tlast.
- Reset asserted for 1 cycle after 2 beats of a 4-beat packet, then a new packet 0x9 (tlast) -> outputs are 0x00000009 and 0x00000001. The earlier partial data is not included.
- Back-to-back packets {0x1 tlast} and {0x2, 0x3 tlast} with upstream tvalid held high -> output sequence 0x1, 0x1 (tlast), 0x5, 0x2 (tlast). No beat is lost or duplicated.
